// File: rtl/nios_handshake_onchip_ram_ctl_pkg.sv
// Shared types and helpers for the handshake on-chip RAM controller.
// Holds the controller FSM encoding and the maximum supported read latency.
package nios_handshake_mem_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam int MAX_READ_LATENCY = 2;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/nios_handshake_onchip_ram_ctl_if.sv
// Avalon-MM slave bus bundle between the Nios II data master and the RAM controller.
// Master drives the request side; slave returns readdata/readdatavalid/waitrequest.
interface nios_handshake_onchip_ram_ctl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  import nios_handshake_mem_pkg::*;

  localparam int BE_W = be_w(DATA_W);

  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output chipselect, address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/nios_handshake_ram_core.sv
// Single-port byte-enabled RAM, synchronous read-first; q updates one edge after en.
// No backpressure: en low freezes both the array and q.
module nios_handshake_ram_core
  import nios_handshake_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic                we,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  localparam int BE_W = be_w(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // q samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      q <= mem_q[addr];
    end
  end

endmodule

// File: rtl/nios_handshake_onchip_ram_ctl.sv
// Avalon-MM scratch RAM with post-reset clear; reads return READ_LATENCY (1 or 2) edges after accept.
// waitrequest is high while clearing or while clken/reset_req gate the block; gating freezes all state.
module nios_handshake_onchip_ram_ctl
  import nios_handshake_mem_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 10,
  parameter int                DEPTH          = 1024,
  parameter int                READ_LATENCY   = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_req,
  input  logic clken,
  nios_handshake_onchip_ram_ctl_if.slave bus,
  output logic init_done
);

  localparam int            BE_W        = be_w(DATA_W);
  localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR    = AW'(DEPTH - 1);
  localparam state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                      state_q, state_d;
  logic [AW-1:0]               ptr_q, ptr_d;
  logic                        init_done_q, init_done_d;
  logic [MAX_READ_LATENCY-1:0] vld_q, vld_d;
  logic                        rng_q, rng_d;
  logic [DATA_W-1:0]           hold_q, hold_d;

  logic              active;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              in_range;
  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] q_masked;

  assign active          = clken & ~reset_req;
  assign bus.waitrequest = (state_q == ST_CLEAR) | ~active;
  assign accept          = bus.chipselect & ~bus.waitrequest & (bus.read | bus.write);
  assign wr_acc          = accept & bus.write;
  // A simultaneous read and write is treated as a pure write.
  assign rd_acc          = accept & bus.read & ~bus.write;
  assign in_range        = ({1'b0, bus.address} < (ADDR_W + 1)'(DEPTH));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    ram_en      = active;
    ram_we      = 1'b0;
    ram_addr    = bus.address[AW-1:0];
    ram_be      = bus.byteenable;
    ram_wdata   = bus.writedata;
    if (active) begin
      case (state_q)
        ST_CLEAR: begin
          ram_we    = 1'b1;
          ram_addr  = ptr_q;
          ram_be    = '1;
          ram_wdata = CLEAR_VALUE;
          if (ptr_q == LAST_PTR) begin
            state_d     = ST_READY;
            init_done_d = 1'b1;
            ptr_d       = '0;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
        ST_READY: begin
          ram_we      = wr_acc & in_range;
          init_done_d = 1'b1;
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

  nios_handshake_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .addr  (ram_addr),
    .be    (ram_be),
    .we    (ram_we),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Out-of-range reads alias onto real words in the array, so their data is zeroed here.
  assign q_masked = rng_q ? ram_q : '0;

  always_comb begin
    vld_d  = vld_q;
    rng_d  = rng_q;
    hold_d = hold_q;
    if (active) begin
      vld_d = {vld_q[MAX_READ_LATENCY-2:0], rd_acc};
      rng_d = in_range;
      if (vld_q[0]) hold_d = q_masked;
    end
  end

  assign bus.readdatavalid = vld_q[READ_LATENCY-1] & active;
  // hold_q doubles as the latency-2 output register and the latency-1 hold value.
  assign bus.readdata      = (READ_LATENCY == 1 && bus.readdatavalid) ? q_masked : hold_q;
  assign init_done         = init_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      vld_q       <= '0;
      rng_q       <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      vld_q       <= vld_d;
      rng_q       <= rng_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_nios_handshake_onchip_ram_ctl.sv
// Scoreboard bench for the on-chip RAM controller: DEPTH=16, READ_LATENCY=2, fill A5A5A5A5.
// Inputs change at the falling edge right after outputs are sampled there.
module tb_nios_handshake_onchip_ram_ctl;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 16;
  localparam int          RL     = 2;
  localparam logic [31:0] CLR    = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset;
  logic reset_req;
  logic clken;
  logic init_done;

  always #5 clk = ~clk;

  nios_handshake_onchip_ram_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  nios_handshake_onchip_ram_ctl #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .READ_LATENCY   (RL),
    .CLEAR_ON_RESET (1),
    .CLEAR_VALUE    (CLR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reset_req (reset_req),
    .clken     (clken),
    .bus       (bus),
    .init_done (init_done)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          last_acc = 0;
  logic [31:0] exp_q [$];
  int          pulse_cyc [$];
  logic [31:0] mem_m [DEPTH];

  // Advance to the next falling edge and score any readdatavalid pulse.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    if (bus.readdatavalid === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rdv: readdata=%h with no read outstanding (cycle %0d)", bus.readdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.readdata !== e) begin
          fails++;
          $display("FAIL readdata: got %h expected %h (cycle %0d)", bus.readdata, e, cyc);
        end
      end
    end
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = '1;
    bus.address    = '0;
    bus.writedata  = '0;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    #1;
    while (bus.waitrequest !== 1'b0 && n < 50) begin
      cycle();
      n++;
    end
    if (bus.waitrequest !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL %s_accept_timeout: waitrequest=%b after %0d cycles, required 0", name, bus.waitrequest, n);
    end
    last_acc = cyc;
  endtask

  task automatic do_read(input int addr, input bit push = 1'b1);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = ADDR_W'(addr);
    bus.byteenable = '1;
    wait_accept("read");
    if (push) exp_q.push_back((addr < DEPTH) ? mem_m[addr] : 32'h0);
    cycle();
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] be, input bit rd = 1'b0);
    bus.chipselect = 1'b1;
    bus.read       = rd;
    bus.write      = 1'b1;
    bus.address    = ADDR_W'(addr);
    bus.byteenable = be;
    bus.writedata  = data;
    wait_accept("write");
    if (addr < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[addr][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    cycle();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      cycle();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d reads never returned, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    #1;
    while (bus.waitrequest === 1'b1 && n < 100) begin
      n++;
      cycle();
    end
    tests++;
    if (n != DEPTH) begin
      fails++;
      $display("FAIL %s_clear_cycles: waitrequest high for %0d cycles, required %0d", name, n, DEPTH);
    end
    tests++;
    if (init_done !== 1'b1) begin
      fails++;
      $display("FAIL %s_init_done: got %b after clear, required 1", name, init_done);
    end
    for (int a = 0; a < DEPTH; a++) mem_m[a] = CLR;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    tests++;
    if (bus.readdatavalid !== 1'b0) begin fails++; $display("FAIL reset_rdv: got %b required 0", bus.readdatavalid); end
    tests++;
    if (bus.readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata: got %h required 0", bus.readdata); end
    tests++;
    if (bus.waitrequest !== 1'b1) begin fails++; $display("FAIL reset_waitrequest: got %b required 1", bus.waitrequest); end
    tests++;
    if (init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b required 0", init_done); end
    reset = 1'b0;
    count_clear("reset");
    for (int a = 0; a < DEPTH; a++) do_read(a);
    idle();
    drain("reset_reads");
  endtask

  task automatic test_byte_enable();
    do_write(3, 32'h11223344, 4'b1111);
    do_write(3, 32'hFFFFFFFF, 4'b0010);
    do_read(3, 1'b0);
    exp_q.push_back(32'h1122FF44);
    idle();
    drain("byte_enable");
  endtask

  task automatic test_write_then_read();
    do_write(6, 32'hCAFE0006, 4'b1111);
    do_read(6, 1'b0);
    exp_q.push_back(32'hCAFE0006);
    idle();
    drain("write_then_read");
  endtask

  task automatic test_back_to_back();
    int first;
    pulse_cyc.delete();
    for (int a = 0; a < 8; a++) begin
      do_read(a);
      if (a == 0) first = last_acc;
    end
    idle();
    drain("back_to_back");
    tests++;
    if (pulse_cyc.size() != 8) begin
      fails++;
      $display("FAIL b2b_pulse_count: got %0d pulses required 8", pulse_cyc.size());
    end else begin
      tests++;
      if (pulse_cyc[0] != first + RL) begin
        fails++;
        $display("FAIL b2b_first_latency: got %0d cycles required %0d", pulse_cyc[0] - first, RL);
      end
      tests++;
      if (pulse_cyc[7] - pulse_cyc[0] != 7) begin
        fails++;
        $display("FAIL b2b_consecutive: 8 pulses spanned %0d cycles, required 7", pulse_cyc[7] - pulse_cyc[0]);
      end
    end
    repeat (3) cycle();
    tests++;
    if (bus.readdata !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL readdata_hold: got %h required A5A5A5A5", bus.readdata);
    end
  endtask

  task automatic test_clken_stall();
    int p0;
    do_write(9, 32'h99887766, 4'b1111);
    idle();
    p0 = pulses;
    do_read(9);
    idle();
    clken = 1'b0;
    #1;
    tests++;
    if (bus.waitrequest !== 1'b1) begin fails++; $display("FAIL clken_waitrequest: got %b required 1", bus.waitrequest); end
    repeat (3) cycle();
    tests++;
    if (pulses != p0) begin fails++; $display("FAIL clken_stall_pulses: got %0d pulses required 0", pulses - p0); end
    clken = 1'b1;
    drain("clken_stall");
    repeat (3) cycle();
    tests++;
    if (pulses != p0 + 1) begin fails++; $display("FAIL clken_resume_pulses: got %0d pulses required 1", pulses - p0); end
    reset_req = 1'b1;
    #1;
    tests++;
    if (bus.waitrequest !== 1'b1) begin fails++; $display("FAIL reset_req_waitrequest: got %b required 1", bus.waitrequest); end
    cycle();
    reset_req = 1'b0;
  endtask

  task automatic test_collision_and_range();
    int p0;
    p0 = pulses;
    do_write(5, 32'hDEADBEEF, 4'b1111, 1'b1);
    idle();
    repeat (4) cycle();
    tests++;
    if (pulses != p0) begin fails++; $display("FAIL rw_dropped_read: got %0d pulses required 0", pulses - p0); end
    do_read(5, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    do_read(20, 1'b0);
    exp_q.push_back(32'h0);
    do_write(20, 32'h12345678, 4'b1111);
    do_read(4);
    idle();
    drain("collision_range");
  endtask

  task automatic test_reset_mid_clear();
    int p0;
    p0 = pulses;
    do_read(2, 1'b0);
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (7) cycle();
    tests++;
    if (init_done !== 1'b0 || bus.waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear_state: init_done=%b waitrequest=%b required 0/1", init_done, bus.waitrequest);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    count_clear("mid_clear");
    tests++;
    if (pulses != p0) begin fails++; $display("FAIL flushed_read: got %0d pulses required 0", pulses - p0); end
    do_read(5);
    do_read(3);
    idle();
    drain("after_reclear");
  endtask

  initial begin
    reset     = 1'b1;
    reset_req = 1'b0;
    clken     = 1'b1;
    idle();
    test_reset();
    test_byte_enable();
    test_write_then_read();
    test_back_to_back();
    test_clken_stall();
    test_collision_and_range();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
